instruction_memory: RTL and testbench

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

---
 rtl/instruction_memory.sv | 66 ++++++
 tb/tb_instruction_memory.sv | 100 ++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
// Read-only instruction store with a one-cycle registered fetch port.
// Byte addresses are word-aligned by dropping the two low bits.
module instruction_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_Address,
    output logic [DATA_WIDTH-1:0] o_Instruction
);

    localparam int IDX_W     = DATA_WIDTH - 2;
    localparam int ADDR_BITS = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Boot program; every other location reads as zero.
    function automatic logic [DATA_WIDTH-1:0] init_word(input int idx);
        logic [DATA_WIDTH-1:0] word;
        case (idx)
            0:       word = DATA_WIDTH'(32'hE3A00014);  // MOV R0,#20
            1:       word = DATA_WIDTH'(32'hE3A01005);  // MOV R1,#5
            2:       word = DATA_WIDTH'(32'hE0802001);  // ADD R2,R0,R1
            3:       word = DATA_WIDTH'(32'hE0403001);  // SUB R3,R0,R1
            4:       word = DATA_WIDTH'(32'hEAFFFFFE);  // B .
            default: word = '0;
        endcase
        return word;
    endfunction

    logic [DATA_WIDTH-1:0] rom [MEM_DEPTH];

    for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_rom
        assign rom[gi] = init_word(gi);
    end

    logic [IDX_W-1:0]      word_index;
    logic [ADDR_BITS-1:0]  rom_addr;
    logic                  in_range;
    logic                  unused_low_bits;
    logic [DATA_WIDTH-1:0] instr_reg;
    logic [DATA_WIDTH-1:0] instr_next;

    assign word_index      = i_Address[DATA_WIDTH-1:2];
    assign unused_low_bits = ^i_Address[1:0];
    assign rom_addr        = word_index[ADDR_BITS-1:0];
    // Compare the full index so out-of-range addresses never alias onto low words.
    assign in_range        = (word_index < IDX_W'(MEM_DEPTH));

    always_comb begin
        instr_next = '0;
        if (in_range) begin
            instr_next = rom[rom_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_reg <= '0;
        end else begin
            instr_reg <= instr_next;
        end
    end

    assign o_Instruction = instr_reg;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed-vector bench for instruction_memory: reset, fetch, alignment,
// range, asynchronous reset and mid-cycle address changes.
module tb_instruction_memory;

    logic        clk;
    logic        reset;
    logic [31:0] i_Address;
    logic [31:0] o_Instruction;

    int check_count = 0;
    int pass_count  = 0;

    instruction_memory #(
        .DATA_WIDTH(32),
        .MEM_DEPTH (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_Address    (i_Address),
        .o_Instruction(o_Instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs === exp) begin
            pass_count++;
            $display("ok   %s: got %h", tag, obs);
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        i_Address = addr;
        @(posedge clk);
        #1;
        check(tag, o_Instruction, exp);
    endtask

    initial begin
        reset     = 1'b0;
        i_Address = 32'h0;

        // Held in reset across two edges: output stays clear.
        @(posedge clk); #1; check("reset_c1", o_Instruction, 32'h0);
        @(posedge clk); #1; check("reset_c2", o_Instruction, 32'h0);

        @(negedge clk);
        reset = 1'b1;

        fetch("seq_0x00", 32'h00, 32'hE3A00014);
        fetch("seq_0x04", 32'h04, 32'hE3A01005);
        fetch("seq_0x08", 32'h08, 32'hE0802001);
        fetch("seq_0x0C", 32'h0C, 32'hE0403001);
        fetch("seq_0x10", 32'h10, 32'hEAFFFFFE);

        fetch("align_5", 32'h05, 32'hE3A01005);
        fetch("align_7", 32'h07, 32'hE3A01005);
        fetch("align_E", 32'h0E, 32'hE0403001);

        fetch("range_100",  32'h100,      32'h0);
        fetch("range_top",  32'hFFFFFFFC, 32'h0);
        fetch("range_x104", 32'h104,      32'h0);
        fetch("range_14",   32'h14,       32'h0);

        // Asynchronous reset between edges.
        fetch("pre_arst", 32'h08, 32'hE0802001);
        #3;
        reset = 1'b0;
        #1;
        check("arst_clear", o_Instruction, 32'h0);
        i_Address = 32'h0;
        @(posedge clk); #1; check("arst_hold", o_Instruction, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1; check("arst_release", o_Instruction, 32'hE3A00014);

        // Two address changes inside one cycle; only the last is captured.
        @(negedge clk);
        i_Address = 32'h04;
        #2;
        i_Address = 32'h0C;
        #1;
        check("midcyc_hold", o_Instruction, 32'hE3A00014);
        @(posedge clk); #1; check("midcyc_edge", o_Instruction, 32'hE0403001);
        #2;
        i_Address = 32'h10;
        #1;
        check("between_edges", o_Instruction, 32'hE0403001);
        @(posedge clk); #1; check("next_edge", o_Instruction, 32'hEAFFFFFE);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
